// File: rtl/bp_common_pkg.sv
// Shared definitions for the sacc scratchpad arbiter.
//   bp_spm_src_e             : identifies which requester a grant/response belongs to
//   spm_wr_cnt_width_gp       : width of the accepted-write counter
//   spm_conflict_cnt_width_gp : width of the contention counter
package bp_common_pkg;

  typedef enum logic {
    e_spm_src_host  = 1'b0,
    e_spm_src_accel = 1'b1
  } bp_spm_src_e;

  localparam int spm_wr_cnt_width_gp       = 10;
  localparam int spm_conflict_cnt_width_gp = 16;

endpackage

// File: rtl/bp_sacc_spm_resp_slot.sv
// One-entry read response slot with a bypass path.
// A response arriving this cycle (load_i) is presented immediately on v_o/data_o;
// if the consumer does not take it the same cycle it is captured and held stable.
// Ports:
//   clk_i, reset_n_i : clock, async active-low reset
//   load_i           : read data arrives this cycle on data_i
//   data_i           : read data from the SRAM path
//   ready_and_i      : consumer accepts the response this cycle
//   v_o, data_o      : response valid / data (data_o is zero when empty)
module bp_sacc_spm_resp_slot #(
  parameter int width_p = 64
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic [width_p-1:0] data_i,
  input  logic               ready_and_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  logic               full_q, full_d;
  logic [width_p-1:0] data_q, data_d;

  // A held entry leaves when taken; a fresh entry is only stored if it was not
  // taken on arrival. The arbiter never loads while an entry is held and not draining.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q) begin
      if (ready_and_i) begin
        full_d = 1'b0;
      end
    end else if (load_i && !ready_and_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  // Slot state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign v_o    = full_q | load_i;
  assign data_o = full_q ? data_q : (load_i ? data_i : '0);

endmodule

// File: rtl/bsg_mem_1rw_sync.sv
// Single-port synchronous SRAM model, one access per cycle.
// Ports:
//   clk_i  : clock
//   v_i    : access enable
//   w_i    : 1 = write, 0 = read
//   addr_i : word address, must be < els_p when v_i is high
//   data_i : write data
//   data_o : read data, valid the cycle after a read; holds until the next read
module bsg_mem_1rw_sync #(
  parameter int width_p = 64,
  parameter int els_p   = 20,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] data_q;

  // Storage array and registered read port; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (v_i && w_i) begin
      mem_q[addr_i] <= data_i;
    end
    if (v_i && !w_i) begin
      data_q <= mem_q[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bp_sacc_spm_arbiter.sv
// Round-robin arbiter giving a host CSR path and an accelerator compute path
// shared access to one single-port scratchpad SRAM.
// Optional feature: define BP_SACC_SPM_ARB_STATS_EN to build the contention
// counter on conflict_cnt_o; otherwise that port is tied to zero.
// Ports:
//   clk_i, reset_n_i          : clock, async active-low reset
//   h_*_i / h_ready_and_o     : host request (valid, write, address, data)
//   h_data_o, h_v_o, h_ready_and_i : host read response
//   a_*                       : same pair of interfaces for the accelerator
//   wr_cnt_o                  : accepted in-range writes, saturating
//   conflict_cnt_o            : cycles where both requesters were eligible, saturating
module bp_sacc_spm_arbiter
  import bp_common_pkg::*;
#(
  parameter int els_p   = 20,
  parameter int width_p = 64,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic                                 h_v_i,
  input  logic                                 h_w_i,
  input  logic [addr_width_lp-1:0]             h_addr_i,
  input  logic [width_p-1:0]                   h_data_i,
  output logic                                 h_ready_and_o,
  output logic [width_p-1:0]                   h_data_o,
  output logic                                 h_v_o,
  input  logic                                 h_ready_and_i,
  input  logic                                 a_v_i,
  input  logic                                 a_w_i,
  input  logic [addr_width_lp-1:0]             a_addr_i,
  input  logic [width_p-1:0]                   a_data_i,
  output logic                                 a_ready_and_o,
  output logic [width_p-1:0]                   a_data_o,
  output logic                                 a_v_o,
  input  logic                                 a_ready_and_i,
  output logic [spm_wr_cnt_width_gp-1:0]       wr_cnt_o,
  output logic [spm_conflict_cnt_width_gp-1:0] conflict_cnt_o
);

  bp_spm_src_e lastGnt_q, lastGnt_d;
  bp_spm_src_e rdSrc_q, rdSrc_d;
  logic        rdPend_q, rdPend_d;
  logic        rdZero_q, rdZero_d;
  logic [spm_wr_cnt_width_gp-1:0] wrCnt_q, wrCnt_d;

  logic hOk, aOk, hElig, aElig, hGnt, aGnt;
  logic reqGnt, reqW, reqInRange;
  logic [addr_width_lp-1:0] reqAddr;
  logic [width_p-1:0]       reqData, memData, rdData;

  // A requester may go if it writes or its response slot will have room.
  // None of these terms look at the requester's own valid, so its ready
  // only depends on its slot and on the other side's request.
  assign hOk   = h_w_i | ~h_v_o | h_ready_and_i;
  assign aOk   = a_w_i | ~a_v_o | a_ready_and_i;
  assign hElig = h_v_i & hOk;
  assign aElig = a_v_i & aOk;

  // The side that did not win last has priority; the other side only gets
  // through when the priority side is not eligible.
  assign h_ready_and_o = reset_n_i & hOk & ((lastGnt_q == e_spm_src_accel) | ~aElig);
  assign a_ready_and_o = reset_n_i & aOk & ((lastGnt_q == e_spm_src_host)  | ~hElig);
  assign hGnt = h_v_i & h_ready_and_o;
  assign aGnt = a_v_i & a_ready_and_o;

  assign reqGnt     = hGnt | aGnt;
  assign reqW       = hGnt ? h_w_i    : a_w_i;
  assign reqAddr    = hGnt ? h_addr_i : a_addr_i;
  assign reqData    = hGnt ? h_data_i : a_data_i;
  assign reqInRange = int'(reqAddr) < els_p;

  // Out-of-range requests are accepted but never touch the array.
  bsg_mem_1rw_sync #(
    .width_p (width_p),
    .els_p   (els_p)
  ) mem (
    .clk_i  (clk_i),
    .v_i    (reqGnt & reqInRange),
    .w_i    (reqW),
    .addr_i (reqAddr),
    .data_i (reqData),
    .data_o (memData)
  );

  // Next-state for the grant pointer, the one-deep read pipeline tag and the
  // saturating write counter.
  always_comb begin
    lastGnt_d = lastGnt_q;
    rdPend_d  = reqGnt & ~reqW;
    rdSrc_d   = hGnt ? e_spm_src_host : e_spm_src_accel;
    rdZero_d  = ~reqInRange;
    wrCnt_d   = wrCnt_q;
    if (hGnt) begin
      lastGnt_d = e_spm_src_host;
    end else if (aGnt) begin
      lastGnt_d = e_spm_src_accel;
    end
    if (reqGnt && reqW && reqInRange && (wrCnt_q != '1)) begin
      wrCnt_d = wrCnt_q + spm_wr_cnt_width_gp'(1);
    end
  end

  // Reset drops any read in flight and hands first contention to the host.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lastGnt_q <= e_spm_src_accel;
      rdSrc_q   <= e_spm_src_host;
      rdPend_q  <= 1'b0;
      rdZero_q  <= 1'b0;
      wrCnt_q   <= '0;
    end else begin
      lastGnt_q <= lastGnt_d;
      rdSrc_q   <= rdSrc_d;
      rdPend_q  <= rdPend_d;
      rdZero_q  <= rdZero_d;
      wrCnt_q   <= wrCnt_d;
    end
  end

  assign rdData   = rdZero_q ? '0 : memData;
  assign wr_cnt_o = wrCnt_q;

  bp_sacc_spm_resp_slot #(.width_p(width_p)) hSlot (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .load_i      (rdPend_q & (rdSrc_q == e_spm_src_host)),
    .data_i      (rdData),
    .ready_and_i (h_ready_and_i),
    .v_o         (h_v_o),
    .data_o      (h_data_o)
  );

  bp_sacc_spm_resp_slot #(.width_p(width_p)) aSlot (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .load_i      (rdPend_q & (rdSrc_q == e_spm_src_accel)),
    .data_i      (rdData),
    .ready_and_i (a_ready_and_i),
    .v_o         (a_v_o),
    .data_o      (a_data_o)
  );

`ifdef BP_SACC_SPM_ARB_STATS_EN
  logic [spm_conflict_cnt_width_gp-1:0] conflictCnt_q, conflictCnt_d;

  // Counts cycles in which both sides wanted the SRAM, saturating.
  always_comb begin
    conflictCnt_d = conflictCnt_q;
    if (hElig && aElig && (conflictCnt_q != '1)) begin
      conflictCnt_d = conflictCnt_q + spm_conflict_cnt_width_gp'(1);
    end
  end

  // Contention counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      conflictCnt_q <= '0;
    end else begin
      conflictCnt_q <= conflictCnt_d;
    end
  end

  assign conflict_cnt_o = conflictCnt_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_sacc_spm_arbiter.sv
// Self-checking bench for bp_sacc_spm_arbiter (default parameters).
// A monitor observes every accepted request, updates a reference memory and
// queues the expected read data per requester; responses are popped and
// compared when they are consumed.
module tb_bp_sacc_spm_arbiter;

  localparam int Els = 20;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        h_v_i, h_w_i, h_ready_and_o, h_v_o, h_ready_and_i;
  logic [4:0]  h_addr_i;
  logic [63:0] h_data_i, h_data_o;
  logic        a_v_i, a_w_i, a_ready_and_o, a_v_o, a_ready_and_i;
  logic [4:0]  a_addr_i;
  logic [63:0] a_data_i, a_data_o;
  logic [9:0]  wr_cnt_o;
  logic [15:0] conflict_cnt_o;

`ifdef BP_SACC_SPM_ARB_STATS_EN
  localparam logic [63:0] ExpConflict = 64'd4;
`else
  localparam logic [63:0] ExpConflict = 64'd0;
`endif

  bp_sacc_spm_arbiter dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .h_v_i          (h_v_i),
    .h_w_i          (h_w_i),
    .h_addr_i       (h_addr_i),
    .h_data_i       (h_data_i),
    .h_ready_and_o  (h_ready_and_o),
    .h_data_o       (h_data_o),
    .h_v_o          (h_v_o),
    .h_ready_and_i  (h_ready_and_i),
    .a_v_i          (a_v_i),
    .a_w_i          (a_w_i),
    .a_addr_i       (a_addr_i),
    .a_data_i       (a_data_i),
    .a_ready_and_o  (a_ready_and_o),
    .a_data_o       (a_data_o),
    .a_v_o          (a_v_o),
    .a_ready_and_i  (a_ready_and_i),
    .wr_cnt_o       (wr_cnt_o),
    .conflict_cnt_o (conflict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] data;
    bit          chk;
  } exp_t;

  exp_t        hQ[$];
  exp_t        aQ[$];
  logic [63:0] modelMem [Els];
  bit          known [Els];
  int          wrModel = 0;

  // Comparison helper: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of requests just after the rising edge, then wait for
  // the falling edge so the caller can sample.
  task automatic applyStimulus(input logic hv, input logic hw, input logic [4:0] ha, input logic [63:0] hd,
                               input logic av, input logic aw, input logic [4:0] aa, input logic [63:0] ad,
                               input logic hr, input logic ar);
    @(posedge clk_i);
    #1;
    h_v_i = hv; h_w_i = hw; h_addr_i = ha; h_data_i = hd;
    a_v_i = av; a_w_i = aw; a_addr_i = aa; a_data_i = ad;
    h_ready_and_i = hr; a_ready_and_i = ar;
    @(negedge clk_i);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1);
  endtask

  task automatic resetDut();
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b0;
    h_v_i = 1'b0; a_v_i = 1'b0;
    h_ready_and_i = 1'b1; a_ready_and_i = 1'b1;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
  endtask

  function automatic logic [63:0] expWr();
    return (wrModel > 1023) ? 64'd1023 : 64'(wrModel);
  endfunction

  // Reference model update for one accepted request.
  task automatic modelGrant(input bit isHost, input logic w, input logic [4:0] addr, input logic [63:0] d);
    exp_t e;
    if (w) begin
      if (addr < Els) begin
        modelMem[addr] = d;
        known[addr]    = 1'b1;
        wrModel++;
      end
    end else begin
      e.chk  = (addr >= Els) || known[addr];
      e.data = (addr < Els) ? modelMem[addr] : 64'h0;
      if (isHost) hQ.push_back(e);
      else        aQ.push_back(e);
    end
  endtask

  // Monitor: consumed responses are checked before new grants are queued.
  always @(negedge clk_i) begin
    exp_t e;
    if (!reset_n_i) begin
      hQ.delete();
      aQ.delete();
      wrModel = 0;
      for (int i = 0; i < Els; i++) known[i] = 1'b0;
    end else begin
      if (h_v_o && h_ready_and_i) begin
        checkOutput("hRespExpected", 64'(hQ.size() != 0), 64'd1);
        if (hQ.size() != 0) begin
          e = hQ.pop_front();
          if (e.chk) checkOutput("hRespData", h_data_o, e.data);
        end
      end
      if (a_v_o && a_ready_and_i) begin
        checkOutput("aRespExpected", 64'(aQ.size() != 0), 64'd1);
        if (aQ.size() != 0) begin
          e = aQ.pop_front();
          if (e.chk) checkOutput("aRespData", a_data_o, e.data);
        end
      end
      if (h_v_i && h_ready_and_o) modelGrant(1'b1, h_w_i, h_addr_i, h_data_i);
      if (a_v_i && a_ready_and_o) modelGrant(1'b0, a_w_i, a_addr_i, a_data_i);
    end
  end

  typedef struct {
    logic        hv, hw;
    logic [4:0]  ha;
    logic [63:0] hd;
    logic        av, aw;
    logic [4:0]  aa;
    logic [63:0] ad;
    logic        expH, expA;
  } vec_t;

  function automatic vec_t mk(input logic hv, input logic hw, input logic [4:0] ha, input logic [63:0] hd,
                              input logic av, input logic aw, input logic [4:0] aa, input logic [63:0] ad,
                              input logic expH, input logic expA);
    vec_t v;
    v.hv = hv; v.hw = hw; v.ha = ha; v.hd = hd;
    v.av = av; v.aw = aw; v.aa = aa; v.ad = ad;
    v.expH = expH; v.expA = expA;
    return v;
  endfunction

  vec_t vecs [15];

  initial begin
    // Arbitration table, starting from reset (accel marked as last winner).
    vecs[0]  = mk(1'b1, 1'b0, 5'd3,  64'h0,  1'b1, 1'b0, 5'd4, 64'h0,  1'b1, 1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 5'd3,  64'h0,  1'b1, 1'b0, 5'd4, 64'h0,  1'b0, 1'b1);
    vecs[2]  = mk(1'b1, 1'b0, 5'd3,  64'h0,  1'b1, 1'b0, 5'd4, 64'h0,  1'b1, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 5'd3,  64'h0,  1'b1, 1'b0, 5'd4, 64'h0,  1'b0, 1'b1);
    vecs[4]  = mk(1'b0, 1'b0, 5'd0,  64'h0,  1'b1, 1'b1, 5'd5, 64'h55, 1'b0, 1'b1);
    vecs[5]  = mk(1'b1, 1'b1, 5'd5,  64'h66, 1'b0, 1'b0, 5'd0, 64'h0,  1'b1, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 5'd5,  64'h0,  1'b1, 1'b1, 5'd6, 64'h77, 1'b0, 1'b1);
    vecs[7]  = mk(1'b1, 1'b0, 5'd5,  64'h0,  1'b1, 1'b0, 5'd6, 64'h0,  1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 5'd0,  64'h0,  1'b1, 1'b0, 5'd6, 64'h0,  1'b0, 1'b1);
    vecs[9]  = mk(1'b1, 1'b1, 5'd25, 64'h99, 1'b1, 1'b1, 5'd7, 64'h88, 1'b1, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 5'd25, 64'h0,  1'b0, 1'b0, 5'd0, 64'h0,  1'b1, 1'b0);
    vecs[11] = mk(1'b0, 1'b0, 5'd0,  64'h0,  1'b1, 1'b0, 5'd7, 64'h0,  1'b0, 1'b1);
    vecs[12] = mk(1'b1, 1'b1, 5'd8,  64'hAA, 1'b1, 1'b1, 5'd8, 64'hBB, 1'b1, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 5'd8,  64'h0,  1'b1, 1'b1, 5'd8, 64'hBB, 1'b0, 1'b1);
    vecs[14] = mk(1'b1, 1'b0, 5'd8,  64'h0,  1'b0, 1'b0, 5'd0, 64'h0,  1'b1, 1'b0);

    // Outputs held at zero while reset is low, even with requests pending.
    reset_n_i = 1'b0;
    h_v_i = 1'b1; h_w_i = 1'b1; h_addr_i = 5'd1; h_data_i = 64'h1;
    a_v_i = 1'b1; a_w_i = 1'b1; a_addr_i = 5'd2; a_data_i = 64'h2;
    h_ready_and_i = 1'b1; a_ready_and_i = 1'b1;
    #2;
    checkOutput("rstHReady",   64'(h_ready_and_o),  64'd0);
    checkOutput("rstAReady",   64'(a_ready_and_o),  64'd0);
    checkOutput("rstHV",       64'(h_v_o),          64'd0);
    checkOutput("rstAV",       64'(a_v_o),          64'd0);
    checkOutput("rstHData",    h_data_o,            64'd0);
    checkOutput("rstAData",    a_data_o,            64'd0);
    checkOutput("rstWrCnt",    64'(wr_cnt_o),       64'd0);
    checkOutput("rstConflict", 64'(conflict_cnt_o), 64'd0);
    resetDut();

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].hv, vecs[i].hw, vecs[i].ha, vecs[i].hd,
                    vecs[i].av, vecs[i].aw, vecs[i].aa, vecs[i].ad, 1'b1, 1'b1);
      if (vecs[i].hv) checkOutput($sformatf("vec%0dHReady", i), 64'(h_ready_and_o), 64'(vecs[i].expH));
      if (vecs[i].av) checkOutput($sformatf("vec%0dAReady", i), 64'(a_ready_and_o), 64'(vecs[i].expA));
      if (i == 4) checkOutput("conflictCnt", 64'(conflict_cnt_o), ExpConflict);
    end
    idle();
    checkOutput("wrCntTable", 64'(wr_cnt_o), expWr());

    // Host write then read back at address 3.
    resetDut();
    applyStimulus(1'b1, 1'b1, 5'd3, 64'hDEAD, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1);
    checkOutput("wr3Ready", 64'(h_ready_and_o), 64'd1);
    applyStimulus(1'b1, 1'b0, 5'd3, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1);
    checkOutput("rd3Ready", 64'(h_ready_and_o), 64'd1);
    idle();
    checkOutput("rd3Latency", 64'(h_v_o),    64'd1);
    checkOutput("rd3Data",    h_data_o,      64'hDEAD);
    checkOutput("rd3WrCnt",   64'(wr_cnt_o), 64'd1);

    // Out-of-range address: write dropped, read returns zero.
    applyStimulus(1'b1, 1'b1, 5'd25, 64'hBAD, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1);
    checkOutput("oorWrReady", 64'(h_ready_and_o), 64'd1);
    applyStimulus(1'b1, 1'b0, 5'd25, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1);
    idle();
    checkOutput("oorRdV",    64'(h_v_o),    64'd1);
    checkOutput("oorRdData", h_data_o,      64'd0);
    checkOutput("oorWrCnt",  64'(wr_cnt_o), 64'd1);

    // Accel response stalled for five cycles with a second read waiting.
    applyStimulus(1'b1, 1'b1, 5'd10, 64'h1010, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 5'd11, 64'h1111, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 5'd10, 64'h0, 1'b1, 1'b0);
    checkOutput("stallFirstReady", 64'(a_ready_and_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd10, 64'h0, 1'b1, 1'b0, 5'd11, 64'h0, 1'b1, 1'b0);
      checkOutput($sformatf("stall%0dAReady", i), 64'(a_ready_and_o), 64'd0);
      checkOutput($sformatf("stall%0dAV", i),     64'(a_v_o),         64'd1);
      checkOutput($sformatf("stall%0dAData", i),  a_data_o,           64'h1010);
      checkOutput($sformatf("stall%0dHReady", i), 64'(h_ready_and_o), 64'd1);
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b0, 5'd11, 64'h0, 1'b1, 1'b1);
    checkOutput("stallReleaseReady", 64'(a_ready_and_o), 64'd1);
    idle();
    checkOutput("stallSecondV",    64'(a_v_o), 64'd1);
    checkOutput("stallSecondData", a_data_o,   64'h1111);

    // Saturation of the write counter.
    for (int i = 0; i < 1030; i++) begin
      applyStimulus(1'b1, 1'b1, 5'(i % Els), 64'(i), 1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1);
    end
    idle();
    checkOutput("wrCntSat",      64'(wr_cnt_o), 64'd1023);
    checkOutput("wrCntSatModel", 64'(wr_cnt_o), expWr());

    // Reset asserted while a read is in flight.
    applyStimulus(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1);
    checkOutput("flightReady", 64'(h_ready_and_o), 64'd1);
    @(posedge clk_i);
    #1;
    checkOutput("flightVBefore", 64'(h_v_o), 64'd1);
    reset_n_i = 1'b0;
    #1;
    checkOutput("flightVReset",     64'(h_v_o),         64'd0);
    checkOutput("flightDataReset",  h_data_o,           64'd0);
    checkOutput("flightReadyReset", 64'(h_ready_and_o), 64'd0);
    checkOutput("flightWrCntReset", 64'(wr_cnt_o),      64'd0);
    h_v_i = 1'b0;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput($sformatf("flightNoResp%0d", i), 64'(h_v_o), 64'd0);
    end

    idle();
    checkOutput("hQueueEmpty", 64'(hQ.size()), 64'd0);
    checkOutput("aQueueEmpty", 64'(aQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
